// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Data-memory slave sitting at the far end of the processor's data port.
// Each in-range load or store is stalled for WAIT_CYCLES cycles by holding
// DataWaitreq high. The access then completes in one further cycle:
//   - a load presents the word on DataIn combinationally;
//   - a store writes DataOut into the internal array at the clock edge.
// Out-of-range and malformed requests raise sticky error flags. Saturating
// counters track completed loads, completed stores and stall cycles.
//
// Ports
//   Clock, Resetn          rising-edge clock, asynchronous active-low reset
//   DataAddr, DataOut      word address and store data from the processor
//   ReadData, WriteData    load / store request strobes
//   DataIn                 load data, non-zero only in a load completion cycle
//   DataWaitreq            processor must hold its request and stall
//   StatClear, ErrClear    synchronous clears for the counters / sticky flags
//   RangeErr, ProtErr      sticky out-of-range / protocol-violation flags
//   ReadCount, WriteCount  completed in-range loads / stores (saturating)
//   StallCount             cycles with DataWaitreq high (saturating)
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int WORD_SIZE   = 16,
    parameter int DEPTH       = 256,
    parameter int ADDR_BASE   = 0,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic [WORD_SIZE-1:0] DataAddr,
    input  logic [WORD_SIZE-1:0] DataOut,
    input  logic                 ReadData,
    input  logic                 WriteData,
    output logic [WORD_SIZE-1:0] DataIn,
    output logic                 DataWaitreq,
    input  logic                 StatClear,
    input  logic                 ErrClear,
    output logic                 RangeErr,
    output logic                 ProtErr,
    output logic [WORD_SIZE-1:0] ReadCount,
    output logic [WORD_SIZE-1:0] WriteCount,
    output logic [WORD_SIZE-1:0] StallCount
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0]        CNT_RELOAD = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;
    localparam logic [WORD_SIZE-1:0] BASE       = WORD_SIZE'(ADDR_BASE);
    // One extra bit so DEPTH == 2**WORD_SIZE still compares correctly.
    localparam logic [WORD_SIZE:0]   DEPTH_W    = (WORD_SIZE + 1)'(DEPTH);
    localparam logic [WORD_SIZE-1:0] ALL_ONES   = '1;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    logic [WORD_SIZE-1:0] mem [DEPTH];

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic                 op_q, op_d;
    logic [WORD_SIZE-1:0] wdata_q, wdata_d;
    logic                 range_err_q, range_err_d;
    logic                 prot_err_q, prot_err_d;
    logic [WORD_SIZE-1:0] read_cnt_q, read_cnt_d;
    logic [WORD_SIZE-1:0] write_cnt_q, write_cnt_d;
    logic [WORD_SIZE-1:0] stall_cnt_q, stall_cnt_d;

    logic                 req, both, in_range, changed;
    logic [WORD_SIZE-1:0] offset;
    logic [AW-1:0]        index;
    logic                 wait_req, complete, accept, prot_set, range_set;
    logic                 wait_req_g, complete_g;

    assign req      = ReadData ^ WriteData;
    assign both     = ReadData & WriteData;
    assign offset   = DataAddr - BASE;
    assign in_range = {1'b0, offset} < DEPTH_W;
    assign index    = offset[AW-1:0];
    // Store data only matters for stores; a load may let DataOut float.
    assign changed  = (DataAddr != addr_q) || (WriteData != op_q) ||
                      (WriteData && (DataOut != wdata_q));

    // Next-state logic. Both IDLE and a WAIT cycle whose request changed fall
    // into the common "accept" path, which decides between an out-of-range
    // drop, a zero-wait completion, or starting a new stall sequence.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        op_d      = op_q;
        wdata_d   = wdata_q;
        wait_req  = 1'b0;
        complete  = 1'b0;
        accept    = 1'b0;
        prot_set  = 1'b0;
        range_set = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (both) begin
                    prot_set = 1'b1;
                end else if (req) begin
                    accept = 1'b1;
                end
            end
            S_WAIT: begin
                if (both || !req) begin
                    prot_set = 1'b1;
                    state_d  = S_IDLE;
                end else if (changed) begin
                    prot_set = 1'b1;
                    accept   = 1'b1;
                end else if (cnt_q != '0) begin
                    wait_req = 1'b1;
                    cnt_d    = cnt_q - CW'(1);
                end else begin
                    complete = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            if (!in_range) begin
                range_set = 1'b1;
                state_d   = S_IDLE;
            end else if (WAIT_CYCLES == 0) begin
                complete = 1'b1;
                state_d  = S_IDLE;
            end else begin
                wait_req = 1'b1;
                addr_d   = DataAddr;
                op_d     = WriteData;
                wdata_d  = DataOut;
                cnt_d    = CNT_RELOAD;
                state_d  = S_WAIT;
            end
        end
    end

    // The combinational outputs are forced quiet while reset is held, so a
    // request still asserted by the processor cannot leak through.
    assign wait_req_g  = wait_req & Resetn;
    assign complete_g  = complete & Resetn;
    assign DataWaitreq = wait_req_g;
    assign DataIn      = (complete_g && ReadData) ? mem[index] : '0;

    // Sticky flags and saturating counters; a fresh error beats ErrClear and
    // StatClear beats any increment.
    always_comb begin
        range_err_d = (ErrClear ? 1'b0 : range_err_q) | range_set;
        prot_err_d  = (ErrClear ? 1'b0 : prot_err_q) | prot_set;
        read_cnt_d  = read_cnt_q;
        write_cnt_d = write_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (complete_g && ReadData && read_cnt_q != ALL_ONES) begin
            read_cnt_d = read_cnt_q + 1'b1;
        end
        if (complete_g && WriteData && write_cnt_q != ALL_ONES) begin
            write_cnt_d = write_cnt_q + 1'b1;
        end
        if (wait_req_g && stall_cnt_q != ALL_ONES) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (StatClear) begin
            read_cnt_d  = '0;
            write_cnt_d = '0;
            stall_cnt_d = '0;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            op_q        <= 1'b0;
            wdata_q     <= '0;
            range_err_q <= 1'b0;
            prot_err_q  <= 1'b0;
            read_cnt_q  <= '0;
            write_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            op_q        <= op_d;
            wdata_q     <= wdata_d;
            range_err_q <= range_err_d;
            prot_err_q  <= prot_err_d;
            read_cnt_q  <= read_cnt_d;
            write_cnt_q <= write_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // The array is deliberately not reset so its contents survive Resetn.
    always_ff @(posedge Clock) begin
        if (complete_g && WriteData) begin
            mem[index] <= DataOut;
        end
    end

    assign RangeErr   = range_err_q;
    assign ProtErr    = prot_err_q;
    assign ReadCount  = read_cnt_q;
    assign WriteCount = write_cnt_q;
    assign StallCount = stall_cnt_q;

endmodule
